// File: rtl/pen_region_decoder.sv
// Pen region decoder: maps a pen sample (x, y, button, page) to a board cell
// and/or a screen region. Board cells are found by walking grid boundaries one
// per cycle (no divider); regions are scanned one table entry per cycle.
// Optional feature macro: CHANGE_ONLY_EN (publish only when the result changes).
module pen_region_decoder #(
  parameter int unsigned COORD_W     = 12,
  parameter int unsigned BOARD_N     = 15,
  localparam int unsigned SEAT_W     = $clog2(BOARD_N + 1),
  parameter int unsigned GRID_SIZE   = 23,
  parameter int unsigned X_BEGIN     = 148,
  parameter int unsigned Y_BEGIN     = 68,
  parameter int unsigned NUM_REGIONS = 4,
  localparam int unsigned REG_W      = $clog2(NUM_REGIONS + 1),
  // Entry i = {page[1:0], x0, x1, y0, y1}, inclusive bounds, entry 0 in LSBs
  parameter logic [NUM_REGIONS*(4*COORD_W+2)-1:0] REGION_TBL = {
    2'd0, COORD_W'(100), COORD_W'(200), COORD_W'(100), COORD_W'(200),
    2'd1, COORD_W'(0), {COORD_W{1'b1}}, COORD_W'(0), {COORD_W{1'b1}},
    2'd1, COORD_W'(520), COORD_W'(615), COORD_W'(352), COORD_W'(383),
    2'd2, COORD_W'(0), {COORD_W{1'b1}}, COORD_W'(0), {COORD_W{1'b1}}
  },
  parameter int unsigned BOARD_PAGE  = 1,
  parameter int unsigned BTN_IDLE    = 3
) (
  input  logic               clk,
  input  logic               rst_p,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [7:0]         btn_i,
  input  logic [1:0]         page_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [SEAT_W-1:0]  seat_x_o,
  output logic [SEAT_W-1:0]  seat_y_o,
  output logic [REG_W-1:0]   region_o,
  output logic [1:0]         area_o,
  output logic [7:0]         btn_o,
  output logic               result_valid_o,
  output logic               btn_valid_o
);

  localparam int unsigned ENT_W = 4 * COORD_W + 2;
  localparam int unsigned CW1   = COORD_W + 1;

  typedef enum logic [1:0] {StIdle, StLocate, StScan, StPublish} state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]         btn_q, btn_d;
  logic [1:0]         page_q, page_d;
  logic [SEAT_W-1:0]  loc_cnt_q, loc_cnt_d;
  logic [REG_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [CW1-1:0]     bnd_x_q, bnd_x_d, bnd_y_q, bnd_y_d;
  logic [SEAT_W-1:0]  sx_q, sx_d, sy_q, sy_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [SEAT_W-1:0]  seat_x_q, seat_x_d, seat_y_q, seat_y_d;
  logic [REG_W-1:0]   region_q, region_d;
  logic [1:0]         area_q, area_d;
  logic [7:0]         btn_out_q, btn_out_d;
  logic               rv_q, rv_d, bv_q, bv_d;
`ifdef CHANGE_ONLY_EN
  logic               published_q, published_d;
`endif

  // Working signals for the per-cycle boundary and table tests
  logic [CW1-1:0]     upper_x, upper_y;
  logic               hit_x, hit_y;
  logic [ENT_W-1:0]   entry;
  logic               ent_match;
  logic               board_hit, btn_evt;
  logic [1:0]         area_new;

  assign ready_o        = (state_q == StIdle);
  assign seat_x_o       = seat_x_q;
  assign seat_y_o       = seat_y_q;
  assign region_o       = region_q;
  assign area_o         = area_q;
  assign btn_o          = btn_out_q;
  assign result_valid_o = rv_q;
  assign btn_valid_o    = bv_q;

  // Current grid cell test on both axes and current region entry test
  always_comb begin
    upper_x = bnd_x_q + CW1'(GRID_SIZE);
    upper_y = bnd_y_q + CW1'(GRID_SIZE);
    hit_x   = ({1'b0, x_q} >= bnd_x_q) && ({1'b0, x_q} < upper_x);
    hit_y   = ({1'b0, y_q} >= bnd_y_q) && ({1'b0, y_q} < upper_y);
    entry   = '0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (scan_cnt_q == REG_W'(i)) entry = REGION_TBL[i*ENT_W +: ENT_W];
    end
    ent_match = (entry[4*COORD_W +: 2] == page_q) &&
                (x_q >= entry[3*COORD_W +: COORD_W]) &&
                (x_q <= entry[2*COORD_W +: COORD_W]) &&
                (y_q >= entry[COORD_W +: COORD_W]) &&
                (y_q <= entry[0 +: COORD_W]);
    board_hit = (page_q == 2'(BOARD_PAGE)) && (sx_q != '0) && (sy_q != '0);
    btn_evt   = (btn_q != 8'd0) && (btn_q != 8'(BTN_IDLE));
    if (board_hit)          area_new = 2'd1;
    else if (reg_q != '0)   area_new = 2'd2;
    else                    area_new = 2'd0;
  end

  // Next-state logic for the FSM and datapath
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    btn_d      = btn_q;
    page_d     = page_q;
    loc_cnt_d  = loc_cnt_q;
    scan_cnt_d = scan_cnt_q;
    bnd_x_d    = bnd_x_q;
    bnd_y_d    = bnd_y_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    reg_d      = reg_q;
    seat_x_d   = seat_x_q;
    seat_y_d   = seat_y_q;
    region_d   = region_q;
    area_d     = area_q;
    btn_out_d  = btn_out_q;
    rv_d       = 1'b0;
    bv_d       = 1'b0;
`ifdef CHANGE_ONLY_EN
    published_d = published_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          x_d        = x_i;
          y_d        = y_i;
          btn_d      = btn_i;
          page_d     = page_i;
          loc_cnt_d  = '0;
          scan_cnt_d = '0;
          bnd_x_d    = CW1'(X_BEGIN);
          bnd_y_d    = CW1'(Y_BEGIN);
          sx_d       = '0;
          sy_d       = '0;
          reg_d      = '0;
          state_d    = StLocate;
        end
      end
      StLocate: begin
        // Cells are disjoint, so at most one cycle hits per axis
        if (hit_y) sx_d = loc_cnt_q + SEAT_W'(1);
        if (hit_x) sy_d = loc_cnt_q + SEAT_W'(1);
        bnd_x_d = upper_x;
        bnd_y_d = upper_y;
        if (loc_cnt_q == SEAT_W'(BOARD_N - 1)) begin
          loc_cnt_d = '0;
          state_d   = StScan;
        end else begin
          loc_cnt_d = loc_cnt_q + SEAT_W'(1);
        end
      end
      StScan: begin
        // Keep the first match so the lowest index wins
        if (ent_match && (reg_q == '0)) reg_d = scan_cnt_q + REG_W'(1);
        if (scan_cnt_q == REG_W'(NUM_REGIONS - 1)) begin
          scan_cnt_d = '0;
          state_d    = StPublish;
        end else begin
          scan_cnt_d = scan_cnt_q + REG_W'(1);
        end
      end
      StPublish: begin
        seat_x_d  = sx_q;
        seat_y_d  = sy_q;
        region_d  = reg_q;
        area_d    = area_new;
        btn_out_d = btn_q;
        bv_d      = btn_evt;
`ifdef CHANGE_ONLY_EN
        rv_d = !published_q || btn_evt || (sx_q != seat_x_q) || (sy_q != seat_y_q) ||
               (reg_q != region_q) || (area_new != area_q);
        published_d = 1'b1;
`else
        rv_d = 1'b1;
`endif
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously by rst_p
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      btn_q      <= '0;
      page_q     <= '0;
      loc_cnt_q  <= '0;
      scan_cnt_q <= '0;
      bnd_x_q    <= '0;
      bnd_y_q    <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      reg_q      <= '0;
      seat_x_q   <= '0;
      seat_y_q   <= '0;
      region_q   <= '0;
      area_q     <= '0;
      btn_out_q  <= '0;
      rv_q       <= 1'b0;
      bv_q       <= 1'b0;
`ifdef CHANGE_ONLY_EN
      published_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      btn_q      <= btn_d;
      page_q     <= page_d;
      loc_cnt_q  <= loc_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      bnd_x_q    <= bnd_x_d;
      bnd_y_q    <= bnd_y_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      reg_q      <= reg_d;
      seat_x_q   <= seat_x_d;
      seat_y_q   <= seat_y_d;
      region_q   <= region_d;
      area_q     <= area_d;
      btn_out_q  <= btn_out_d;
      rv_q       <= rv_d;
      bv_q       <= bv_d;
`ifdef CHANGE_ONLY_EN
      published_q <= published_d;
`endif
    end
  end

endmodule

// File: tb/tb_pen_region_decoder.sv
// Directed bench for pen_region_decoder with default parameters and table.
module tb_pen_region_decoder;

  logic        clk = 1'b0;
  logic        rst_p;
  logic [11:0] x_i, y_i;
  logic [7:0]  btn_i;
  logic [1:0]  page_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  seat_x_o, seat_y_o;
  logic [2:0]  region_o;
  logic [1:0]  area_o;
  logic [7:0]  btn_o;
  logic        result_valid_o, btn_valid_o;

  int n_checks = 0;
  int n_errors = 0;

  pen_region_decoder dut (
    .clk            (clk),
    .rst_p          (rst_p),
    .x_i            (x_i),
    .y_i            (y_i),
    .btn_i          (btn_i),
    .page_i         (page_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .seat_x_o       (seat_x_o),
    .seat_y_o       (seat_y_o),
    .region_o       (region_o),
    .area_o         (area_o),
    .btn_o          (btn_o),
    .result_valid_o (result_valid_o),
    .btn_valid_o    (btn_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int btn; int page;
    int sx; int sy; int rg; int area; int bv;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    x_i    = 12'(v.x);
    y_i    = 12'(v.y);
    btn_i  = 8'(v.btn);
    page_i = 2'(v.page);
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic run_sample(input vec_t v, input string tag);
    int n;
    bit seen;
    bit busy_ok;
    check({tag, " ready"}, int'(ready_o), 1);
    drive(v);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (result_valid_o) seen = 1;
      else if (ready_o) busy_ok = 0;
    end
    check({tag, " latency"}, n, 21);
    check({tag, " busy"}, int'(busy_ok), 1);
    check({tag, " seat_x"}, int'(seat_x_o), v.sx);
    check({tag, " seat_y"}, int'(seat_y_o), v.sy);
    check({tag, " region"}, int'(region_o), v.rg);
    check({tag, " area"}, int'(area_o), v.area);
    check({tag, " btn"}, int'(btn_o), v.btn);
    check({tag, " btn_valid"}, int'(btn_valid_o), v.bv);
    @(negedge clk);
    check({tag, " pulse"}, int'(result_valid_o), 0);
    check({tag, " hold"}, int'(seat_y_o), v.sy);
  endtask

  initial begin
    int last_acc, nacc, nres, cnt;
    vec_t v;
    //          x    y    btn page sx  sy  rg area bv
    tbl[0]  = '{148, 68,  0,  1,   1,  1,  3, 1,   0};
    tbl[1]  = '{492, 411, 0,  1,   15, 15, 3, 1,   0};
    tbl[2]  = '{493, 411, 0,  1,   15, 0,  3, 2,   0};
    tbl[3]  = '{520, 383, 2,  1,   14, 0,  2, 2,   1};
    tbl[4]  = '{147, 67,  5,  2,   0,  0,  1, 2,   1};
    tbl[5]  = '{520, 383, 3,  1,   14, 0,  2, 2,   0};
    tbl[6]  = '{148, 68,  0,  2,   1,  1,  1, 2,   0};
    tbl[7]  = '{150, 150, 1,  0,   4,  1,  4, 2,   1};
    tbl[8]  = '{171, 91,  0,  3,   2,  2,  0, 0,   0};
    tbl[9]  = '{170, 90,  3,  1,   1,  1,  3, 1,   0};
    tbl[10] = '{600, 370, 255, 1,  14, 0,  2, 2,   1};
    tbl[11] = '{616, 383, 0,  1,   14, 0,  3, 2,   0};
    tbl[12] = '{0,   0,   0,  0,   0,  0,  0, 0,   0};

    rst_p = 1'b1; valid_i = 1'b0;
    x_i = '0; y_i = '0; btn_i = '0; page_i = '0;
    repeat (3) @(negedge clk);
    check("reset ready", int'(ready_o), 1);
    check("reset outs", int'({seat_x_o, seat_y_o, region_o, area_o, btn_o,
                             result_valid_o, btn_valid_o}), 0);
    rst_p = 1'b0;
    // First vector is presented in the cycle right after reset release
    for (int i = 0; i < 13; i++) run_sample(tbl[i], $sformatf("vec%0d", i));

    // valid_i held high with changing data: only idle-cycle samples are taken
    last_acc = 0; nacc = 0; nres = 0;
    valid_i = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      if (result_valid_o) begin
        nres++;
        check("cont latency", c - last_acc, 21);
        check("cont seat_y", int'(seat_y_o), (last_acc % 15) + 1);
      end
      if (ready_o) begin
        if (nacc > 0) check("cont gap", c - last_acc, 21);
        last_acc = c;
        nacc++;
      end
      x_i = 12'(148 + 23 * (c % 15)); y_i = 12'd68; page_i = 2'd1; btn_i = 8'd0;
      @(negedge clk);
    end
    valid_i = 1'b0;
    check("cont accepts", nacc, 3);
    check("cont results", nres, 2);
    cnt = 0;
    while (!ready_o && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("cont drain", int'(ready_o), 1);
    @(negedge clk);

    // Reset in the fifth LOCATE cycle discards the sample
    drive(tbl[3]);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_p = 1'b1;
    #1;
    check("midrst ready", int'(ready_o), 1);
    check("midrst outs", int'({seat_x_o, seat_y_o, region_o, area_o, btn_o,
                              result_valid_o, btn_valid_o}), 0);
    @(negedge clk);
    rst_p = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (result_valid_o) cnt++;
    end
    check("midrst no result", cnt, 0);
    run_sample(tbl[1], "postrst");

    // Same sample twice with no button event
    cnt = 0;
    for (int k = 0; k < 2; k++) begin
      v = tbl[0];
      drive(v);
      valid_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (result_valid_o) cnt++;
      end
    end
`ifdef CHANGE_ONLY_EN
    check("repeat results", cnt, 1);
`else
    check("repeat results", cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
